// File: rtl/mem2p_fifo_ctrl_pkg.sv
// mem2p_fifo_pkg: shared defaults, pointer/count carrier types and the wrapping pointer increment.
package mem2p_fifo_pkg;
    localparam int W_DEF = 8;
    localparam int D_DEF = 128;
    typedef logic [31:0] ptr_t;
    typedef logic [31:0] cnt_t;
    // Explicit wrap at d-1 so non-power-of-two depths stay in range.
    function automatic ptr_t wrap_inc(ptr_t ptr, ptr_t d);
        return (ptr == d - 1) ? '0 : ptr + 1;
    endfunction
endpackage

// File: rtl/mem2p_fifo_ctrl_if.sv
// mem2p_fifo_ctrl_if: valid/ready write and read stream ports of the FIFO.
interface mem2p_fifo_ctrl_if #(parameter int W = 8) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/mem2p_fifo_ctrl_ram.sv
// mem2p_sw_sr: two-port RAM, sync write on port 1, registered read address on port 2.
module mem2p_sw_sr #(
    parameter int W = 8,
    parameter int D = 128,
    localparam int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [W-1:0]  din1,
    input  logic [AW-1:0] addr2,
    output logic [W-1:0]  dout2
);
    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_addr2;
    always_ff @(posedge clk) begin
        if (we1) r_mem[addr1] <= din1;
        r_addr2 <= addr2;
    end
    assign dout2 = r_mem[r_addr2];
endmodule

// File: rtl/mem2p_fifo_ctrl.sv
// mem2p_fifo_ctrl: zero-bubble stream FIFO over a two-port RAM.
// Define FIFO_PEAK_EN to add the peak_count occupancy high-water output.
module mem2p_fifo_ctrl
    import mem2p_fifo_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int D      = D_DEF,
    parameter int AF_LVL = D - 4,
    localparam int DW = $clog2(D),
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    mem2p_fifo_ctrl_if.slave bus,
    output logic [CW-1:0] count,
`ifdef FIFO_PEAK_EN
    output logic [CW-1:0] peak_count,
`endif
    output logic          almost_full
);
    logic [DW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt, w_wr_inc, w_rd_inc;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          w_clr, w_push, w_pop;
    assign w_clr     = rst | flush;
    assign bus.in_ready  = (r_count != CW'(D)) & !w_clr;
    assign bus.out_valid = (r_count != '0) & !w_clr;
    assign w_push    = bus.in_valid & bus.in_ready;
    assign w_pop     = bus.out_valid & bus.out_ready;
    assign w_wr_inc  = DW'(wrap_inc(ptr_t'(r_wr_ptr), ptr_t'(D)));
    assign w_rd_inc  = DW'(wrap_inc(ptr_t'(r_rd_ptr), ptr_t'(D)));
    // The RAM registers this address, so its output always tracks r_rd_ptr.
    assign w_rd_ptr_nxt = w_clr ? '0 : w_pop ? w_rd_inc : r_rd_ptr;
    assign w_count_nxt  = w_clr ? '0 : r_count + CW'(w_push) - CW'(w_pop);
    assign count       = r_count;
    assign almost_full = r_count >= CW'(AF_LVL);
    always_ff @(posedge clk) begin
        r_wr_ptr <= w_clr ? '0 : w_push ? w_wr_inc : r_wr_ptr;
        r_rd_ptr <= w_rd_ptr_nxt;
        r_count  <= w_count_nxt;
    end
`ifdef FIFO_PEAK_EN
    logic [CW-1:0] r_peak;
    always_ff @(posedge clk) begin
        r_peak <= w_clr ? '0 : (w_count_nxt > r_peak) ? w_count_nxt : r_peak;
    end
    assign peak_count = r_peak;
`endif
    mem2p_sw_sr #(.W(W), .D(D)) u_ram (
        .clk   (clk),
        .we1   (w_push),
        .addr1 (r_wr_ptr),
        .din1  (bus.in_data),
        .addr2 (w_rd_ptr_nxt),
        .dout2 (bus.out_data)
    );
endmodule

// File: tb/tb_mem2p_fifo_ctrl.sv
// tb_mem2p_fifo_ctrl: table-driven vectors plus hand sequences for a D=4, AF_LVL=3 FIFO.
module tb_mem2p_fifo_ctrl;
    localparam int W = 8, D = 4, AF = 3, CW = $clog2(D + 1);
    typedef struct {
        logic fl, iv; logic [7:0] id; logic ordy;
        logic e_ir, e_ov, chk_d; logic [7:0] e_d; logic [CW-1:0] e_cnt; logic e_af;
    } vec_t;
    logic clk = 0, rst = 1, flush = 0, almost_full;
    logic [CW-1:0] count;
`ifdef FIFO_PEAK_EN
    logic [CW-1:0] peak_count;
`endif
    int n_vec = 0, n_bad = 0;
    vec_t tbl[$];
    mem2p_fifo_ctrl_if #(.W(W)) bus ();
    mem2p_fifo_ctrl #(.W(W), .D(D), .AF_LVL(AF)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus), .count(count),
`ifdef FIFO_PEAK_EN
        .peak_count(peak_count),
`endif
        .almost_full(almost_full)
    );
    always #5 clk = ~clk;
    function automatic vec_t v(logic fl, logic iv, logic [7:0] id, logic ordy, logic ir, logic ov,
                               logic cd, logic [7:0] d, int cnt, logic af);
        vec_t r;
        r.fl = fl; r.iv = iv; r.id = id; r.ordy = ordy; r.e_ir = ir; r.e_ov = ov;
        r.chk_d = cd; r.e_d = d; r.e_cnt = CW'(cnt); r.e_af = af;
        return r;
    endfunction
    task automatic drive(logic fl, logic iv, logic [7:0] id, logic ordy);
        flush = fl; bus.in_valid = iv; bus.in_data = id; bus.out_ready = ordy;
    endtask
    task automatic cyc(logic fl, logic iv, logic [7:0] id, logic ordy);
        drive(fl, iv, id, ordy);
        @(posedge clk); #1;
    endtask
    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    initial begin
        drive(0, 0, 8'h00, 0);
        // Reset then push A5 into empty FIFO; data must appear next cycle.
        tbl.push_back(v(0, 1, 8'hA5, 0, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 1, 1, 1, 8'hA5, 1, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0));
        // Fill with consumer stalled: 4 accepted, 5th held.
        tbl.push_back(v(0, 1, 8'h11, 0, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h22, 0, 1, 1, 1, 8'h11, 1, 0));
        tbl.push_back(v(0, 1, 8'h33, 0, 1, 1, 1, 8'h11, 2, 0));
        tbl.push_back(v(0, 1, 8'h44, 0, 1, 1, 1, 8'h11, 3, 1));
        tbl.push_back(v(0, 1, 8'h55, 0, 0, 1, 1, 8'h11, 4, 1));
        tbl.push_back(v(0, 1, 8'h55, 0, 0, 1, 1, 8'h11, 4, 1));
        // Full with pop: no push this cycle.
        tbl.push_back(v(0, 1, 8'h55, 1, 0, 1, 1, 8'h11, 4, 1));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 1, 1, 8'h22, 3, 1));
        // Steady push+pop at count 2, pointers wrap.
        for (int k = 0; k < 10; k++)
            tbl.push_back(v(0, 1, 8'(8'h60 + k), 1, 1, 1, 1,
                            k == 0 ? 8'h33 : k == 1 ? 8'h44 : 8'(8'h60 + k - 2), 2, 0));
        tbl.push_back(v(0, 1, 8'h70, 0, 1, 1, 1, 8'h68, 2, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 1, 1, 8'h68, 3, 1));
        tbl.push_back(v(0, 0, 8'h00, 0, 1, 1, 1, 8'h69, 2, 0));
        tbl.push_back(v(0, 1, 8'h71, 0, 1, 1, 1, 8'h69, 2, 0));
        // Flush with a concurrent push at count 3.
        tbl.push_back(v(1, 1, 8'h72, 0, 0, 0, 0, 8'h00, 3, 1));
        tbl.push_back(v(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'h80, 0, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 1, 1, 8'h80, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));
        repeat (2) @(posedge clk);
        #1 rst = 0;
        foreach (tbl[i]) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            #1;
            n_vec++;
            if (bus.in_ready !== tbl[i].e_ir || bus.out_valid !== tbl[i].e_ov || count !== tbl[i].e_cnt ||
                almost_full !== tbl[i].e_af || (tbl[i].chk_d && bus.out_data !== tbl[i].e_d)) begin
                n_bad++;
                $display("FAIL vec%0d: ir=%b ov=%b d=%h cnt=%0d af=%b, want ir=%b ov=%b d=%h cnt=%0d af=%b",
                         i, bus.in_ready, bus.out_valid, bus.out_data, count, almost_full,
                         tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_d, tbl[i].e_cnt, tbl[i].e_af);
            end
            @(posedge clk); #1;
        end
        // Reset mid-stream discards stored entries.
        cyc(0, 1, 8'hB1, 0);
        cyc(0, 1, 8'hB2, 0);
        chk("pre_rst_count", int'(count), 2);
        rst = 1;
        cyc(0, 1, 8'hB3, 0);
        rst = 0;
        drive(0, 0, 8'h00, 0);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_almost_full", int'(almost_full), 0);
`ifdef FIFO_PEAK_EN
        chk("rst_peak", int'(peak_count), 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 8'(8'hC0 + k), 0);
        chk("peak_full", int'(peak_count), 4);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 8'h00, 1);
            #1;
            chk("peak_pop_data", int'(bus.out_data), 8'hC0 + k);
            @(posedge clk); #1;
        end
        chk("peak_after_drain", int'(peak_count), 4);
        chk("count_after_drain", int'(count), 0);
        cyc(1, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0);
        chk("peak_after_flush", int'(peak_count), 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
